difftest_int_wb_collector: RTL and testbench
============================================

Name: difftest_int_wb_collector

Overview:
- Upstream feeder for the per-core integer-writeback difftest sink.
- Gathers up to NUM_PORTS integer register-file writebacks per cycle from the backend and buffers them in a FIFO.
- Drains one event per cycle in program-port order onto the single-event sink interface (enable, valid, address, data, coreid).
- Counts events lost to overflow so a silent difftest mismatch can be traced to the buffer.

Parameters:
- NUM_PORTS, 2, writeback ports sampled per cycle (1..4).
- DEPTH, 8, FIFO entries; power of two, DEPTH >= 2*NUM_PORTS.
- DATA_W, 64, writeback data width.
- ADDR_W, 5, architectural register index width.
- CNT_W, 16, overflow counter width.

Ports:
- clock  in  1  sole clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- io_coreid  in  8  static core id; passed through on out_coreid.
- in_valid  in  NUM_PORTS  per-port writeback valid.
- in_address  in  NUM_PORTS*ADDR_W  packed register indices, port 0 in the LSBs.
- in_data  in  NUM_PORTS*DATA_W  packed writeback data, port 0 in the LSBs.
- in_ready  out  1  high when free entries >= NUM_PORTS.
- out_ready  in  1  sink accepts the head entry this cycle; tie high for the DPI sink.
- out_enable  out  1  head entry valid; drives the sink's enable.
- out_valid  out  1  identical to out_enable; drives the sink's io_valid.
- out_address  out  ADDR_W  head register index.
- out_data  out  DATA_W  head data.
- out_coreid  out  8  io_coreid registered alongside the head.
- overflow_cnt  out  CNT_W  saturating count of dropped events.
- overflow_sticky  out  1  set on the first drop; cleared only by reset.

Behaviour:
- Reset (reset==0, asynchronous): clears wr_ptr, rd_ptr, count, overflow_cnt and overflow_sticky. All outputs read 0. FIFO data contents are don't-care.
- Enqueue:
  - A port is "accepted" when in_valid[i] is high, filtered per the Optional Feature.
  - Accepted ports are written in ascending port index at consecutive slots from wr_ptr.
  - wr_ptr advances by the number accepted, modulo DEPTH (natural wrap of log2(DEPTH)-bit pointers).
- Backpressure:
  - in_ready = (DEPTH - count) >= NUM_PORTS, computed from the registered count. Same-cycle pop is not credited.
  - If in_ready==0, every accepted port that cycle is dropped, not enqueued.
  - overflow_cnt += number dropped, saturating at all-ones.
  - overflow_sticky is set to 1.
  - No partial enqueue ever occurs.
- Dequeue:
  - out_enable/out_valid = (count != 0).
  - out_address and out_data come from the FIFO slot at rd_ptr.
  - Pop when out_enable && out_ready; rd_ptr then advances by 1 modulo DEPTH.
- Latency: an event enqueued on edge N appears at the outputs after edge N, earliest in the cycle following enqueue. There is no combinational in→out path.
- Simultaneous push and pop: count_next = count + pushed - popped. The FIFO never exceeds DEPTH, by construction of in_ready.
- Empty: outputs hold their last data values with out_valid=0. The sink must ignore the data.
- out_coreid: registered from io_coreid every cycle.
- Reset mid-drain: in-flight entries are discarded and no event is emitted after reset release until a new enqueue.

Optional Feature:
- Macro: DIFFTEST_WB_FILTER_X0_EN.
- Defined: ports with in_address==0 are not accepted. They are neither enqueued nor counted as drops, since x0 writes are architecturally invisible.
- Undefined: x0 writebacks are enqueued and forwarded like any other register.

Decomposition:
- Shared package difftest_wb_pkg holds:
  - typedef wb_entry_t {addr[ADDR_W], data[DATA_W]};
  - localparams DEFAULT_DEPTH and DEFAULT_PORTS;
  - a function popcount_ports.
- One natural sub-module: difftest_wb_fifo, a multi-write, single-read circular buffer with count.
- The top level holds acceptance filtering, drop accounting and output registering.

Test Plan:
- Reset hold, then release, no input -> out_valid=0, in_ready=1, overflow_cnt=0 for 10 cycles.
- Single event port0 addr=3 data=0xDEAD_BEEF at cycle 5 -> out_valid=1 at cycle 6 with addr=3, data=0xDEADBEEF, out_coreid=io_coreid; out_valid=0 at cycle 7.
- Both ports each cycle with port0 (addr 1, data k) and port1 (addr 2, data k+100), out_ready=1 -> outputs alternate 1,k / 2,k+100 in order; in_ready drops once count exceeds 6, and drops are reflected in overflow_cnt.
- out_ready=0 while 4 two-port bursts arrive (DEPTH=8) -> count=8, in_ready=0. A fifth burst gives overflow_cnt=2 and overflow_sticky=1. Releasing out_ready drains the 8 original events in order across wrap-around.
- DIFFTEST_WB_FILTER_X0_EN defined, port0 addr=0 plus port1 addr=7 -> only addr 7 emitted, overflow_cnt unchanged. Macro undefined -> both emitted, addr 0 first.
- Assert reset mid-drain with 5 queued -> out_valid=0 immediately (asynchronous). After release, no events until new input.

Source files
------------

// File: rtl/difftest_wb_pkg.sv
// Shared types and helpers for the integer-writeback difftest collector.
// Holds the writeback entry type, default sizing and a port popcount helper.
package difftest_wb_pkg;

   localparam int DEFAULT_PORTS = 2;
   localparam int DEFAULT_DEPTH = 8;
   localparam int MAX_PORTS     = 4;
   localparam int WB_ADDR_W     = 5;
   localparam int WB_DATA_W     = 64;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   // Number of set bits in a per-port valid vector (at most MAX_PORTS ports).
   function automatic logic [2:0] popcount_ports(input logic [MAX_PORTS-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/difftest_wb_fifo.sv
// Multi-write, single-read circular buffer with occupancy count.
// Set push bits are packed into consecutive slots from the write pointer in ascending port order.
module difftest_wb_fifo
   import difftest_wb_pkg::*;
#(
   parameter int NUM_PORTS = DEFAULT_PORTS,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int ADDR_W    = WB_ADDR_W,
   parameter int DATA_W    = WB_DATA_W,
   localparam int PTR_W    = $clog2(DEPTH)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          push,
   input  logic [NUM_PORTS*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wr_data,
   input  logic                          pop,
   output logic [ADDR_W-1:0]             head_addr,
   output logic [DATA_W-1:0]             head_data,
   output logic [PTR_W:0]                count
);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [PTR_W-1:0] slot [NUM_PORTS];
   logic [PTR_W:0]   push_n;
   logic             do_pop;

   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      push_n = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         slot[i] = wr_ptr_q + push_n[PTR_W-1:0];
         push_n  = push_n + (PTR_W+1)'(push[i]);
      end
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q + push_n[PTR_W-1:0];
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + push_n - (PTR_W+1)'(do_pop);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; entry validity is carried by count alone.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (push[i]) begin
            addr_mem[slot[i]] <= wr_addr[i*ADDR_W +: ADDR_W];
            data_mem[slot[i]] <= wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign head_addr = addr_mem[rd_ptr_q];
   assign head_data = data_mem[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/difftest_int_wb_collector.sv
// Collects per-cycle integer writebacks into a FIFO and drains one per cycle to the difftest sink.
// Optional build macro DIFFTEST_WB_FILTER_X0_EN drops x0 writebacks before they are accepted.
module difftest_int_wb_collector
   import difftest_wb_pkg::*;
#(
   parameter int NUM_PORTS = DEFAULT_PORTS,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int DATA_W    = WB_DATA_W,
   parameter int ADDR_W    = WB_ADDR_W,
   parameter int CNT_W     = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [7:0]                    io_coreid,
   input  logic [NUM_PORTS-1:0]          in_valid,
   input  logic [NUM_PORTS*ADDR_W-1:0]   in_address,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   output logic                          in_ready,
   input  logic                          out_ready,
   output logic                          out_enable,
   output logic                          out_valid,
   output logic [ADDR_W-1:0]             out_address,
   output logic [DATA_W-1:0]             out_data,
   output logic [7:0]                    out_coreid,
   output logic [CNT_W-1:0]              overflow_cnt,
   output logic                          overflow_sticky
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] PORTS_C = (PTR_W+1)'(NUM_PORTS);

   logic [NUM_PORTS-1:0] accepted;
   logic [NUM_PORTS-1:0] push;
   logic                 ready_raw;
   logic [2:0]           drop_n;
   logic [CNT_W:0]       cnt_sum;
   logic                 head_valid;
   logic [ADDR_W-1:0]    head_addr;
   logic [DATA_W-1:0]    head_data;
   logic [PTR_W:0]       count;

   logic [CNT_W-1:0]  overflow_cnt_q, overflow_cnt_d;
   logic              overflow_sticky_q, overflow_sticky_d;
   logic [7:0]        coreid_q, coreid_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [DATA_W-1:0] last_data_q, last_data_d;

   difftest_wb_fifo #(
      .NUM_PORTS (NUM_PORTS),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .wr_addr   (in_address),
      .wr_data   (in_data),
      .pop       (out_ready),
      .head_addr (head_addr),
      .head_data (head_data),
      .count     (count)
   );

   always_comb begin
      accepted = '0;
`ifdef DIFFTEST_WB_FILTER_X0_EN
      for (int i = 0; i < NUM_PORTS; i++) begin
         accepted[i] = in_valid[i] && (in_address[i*ADDR_W +: ADDR_W] != '0);
      end
`else
      accepted = in_valid;
`endif
      // Space is judged on the registered count only; a same-cycle pop earns no credit.
      ready_raw = (DEPTH_C - count) >= PORTS_C;
      push      = ready_raw ? accepted : '0;
      drop_n    = ready_raw ? 3'd0 : popcount_ports(MAX_PORTS'(accepted));

      cnt_sum           = {1'b0, overflow_cnt_q} + (CNT_W+1)'(drop_n);
      overflow_cnt_d    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      overflow_sticky_d = overflow_sticky_q | (drop_n != 3'd0);

      head_valid  = (count != '0);
      last_addr_d = head_valid ? head_addr : last_addr_q;
      last_data_d = head_valid ? head_data : last_data_q;
      coreid_d    = io_coreid;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow_cnt_q    <= '0;
         overflow_sticky_q <= 1'b0;
         coreid_q          <= '0;
         last_addr_q       <= '0;
         last_data_q       <= '0;
      end else begin
         overflow_cnt_q    <= overflow_cnt_d;
         overflow_sticky_q <= overflow_sticky_d;
         coreid_q          <= coreid_d;
         last_addr_q       <= last_addr_d;
         last_data_q       <= last_data_d;
      end
   end

   // in_ready is held low while reset is asserted so every output reads 0 in reset.
   assign in_ready        = reset & ready_raw;
   assign out_enable      = head_valid;
   assign out_valid       = head_valid;
   assign out_address     = head_valid ? head_addr : last_addr_q;
   assign out_data        = head_valid ? head_data : last_data_q;
   assign out_coreid      = coreid_q;
   assign overflow_cnt    = overflow_cnt_q;
   assign overflow_sticky = overflow_sticky_q;

endmodule

// File: tb/tb_difftest_int_wb_collector.sv
// Directed self-checking bench for difftest_int_wb_collector at default sizing (2 ports, depth 8).
// Expected x0 behaviour follows DIFFTEST_WB_FILTER_X0_EN as seen by this compile.
module tb_difftest_int_wb_collector;
   import difftest_wb_pkg::*;

   localparam int NP = 2;
   localparam int AW = 5;
   localparam int DW = 64;
   localparam int CW = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic [7:0]        io_coreid;
   logic [NP-1:0]     in_valid;
   logic [NP*AW-1:0]  in_address;
   logic [NP*DW-1:0]  in_data;
   logic              in_ready;
   logic              out_ready;
   logic              out_enable;
   logic              out_valid;
   logic [AW-1:0]     out_address;
   logic [DW-1:0]     out_data;
   logic [7:0]        out_coreid;
   logic [CW-1:0]     overflow_cnt;
   logic              overflow_sticky;

   int n_cmp = 0;
   int n_err = 0;

   difftest_int_wb_collector dut (
      .clock           (clock),
      .reset           (reset),
      .io_coreid       (io_coreid),
      .in_valid        (in_valid),
      .in_address      (in_address),
      .in_data         (in_data),
      .in_ready        (in_ready),
      .out_ready       (out_ready),
      .out_enable      (out_enable),
      .out_valid       (out_valid),
      .out_address     (out_address),
      .out_data        (out_data),
      .out_coreid      (out_coreid),
      .overflow_cnt    (overflow_cnt),
      .overflow_sticky (overflow_sticky)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic wb_entry_t mk(input int a, input longint d);
      wb_entry_t e;
      e.addr = 5'(a);
      e.data = 64'(d);
      return e;
   endfunction

   task automatic drive(input logic [1:0] v, input wb_entry_t e0, input wb_entry_t e1);
      in_valid   = v;
      in_address = {e1.addr, e0.addr};
      in_data    = {e1.data, e0.data};
   endtask

   task automatic idle();
      drive(2'b00, mk(0, 0), mk(0, 0));
   endtask

   task automatic check_head(input string tag, input wb_entry_t e);
      check({tag, ".valid"}, 64'(out_valid), 64'd1);
      check({tag, ".addr"},  64'(out_address), 64'(e.addr));
      check({tag, ".data"},  out_data, e.data);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Stream event j: even j from port0 (addr 1, data k), odd j from port1 (addr 2, data k+100).
   function automatic wb_entry_t stream_ev(input int j);
      return (j % 2 == 0) ? mk(1, j / 2) : mk(2, j / 2 + 100);
   endfunction

   // Burst event i: burst i/2, port i%2; data 0x1000+i.
   function automatic wb_entry_t burst_ev(input int i);
      return (i % 2 == 0) ? mk(10 + i / 2, 64'h1000 + i) : mk(20 + i / 2, 64'h1000 + i);
   endfunction

   initial begin
      reset     = 1'b1;
      io_coreid = 8'h2A;
      out_ready = 1'b1;
      idle();

      // Reset asserted: every output reads 0.
      #1 reset = 1'b0;
      #2;
      check("rst.valid",   64'(out_valid), 64'd0);
      check("rst.enable",  64'(out_enable), 64'd0);
      check("rst.in_ready", 64'(in_ready), 64'd0);
      check("rst.ovf",     64'(overflow_cnt), 64'd0);
      check("rst.sticky",  64'(overflow_sticky), 64'd0);
      check("rst.coreid",  64'(out_coreid), 64'd0);
      check("rst.data",    out_data, 64'd0);
      tick();
      tick();
      reset = 1'b1;

      // Idle after release.
      for (int c = 0; c < 10; c++) begin
         tick();
         check("idle.valid",    64'(out_valid), 64'd0);
         check("idle.in_ready", 64'(in_ready), 64'd1);
         check("idle.ovf",      64'(overflow_cnt), 64'd0);
      end
      check("idle.coreid", 64'(out_coreid), 64'h2A);

      // Single event on port 0, visible the cycle after enqueue, gone one cycle later.
      drive(2'b01, mk(3, 64'hDEAD_BEEF), mk(0, 0));
      tick();
      idle();
      check_head("single", mk(3, 64'hDEAD_BEEF));
      check("single.enable", 64'(out_enable), 64'd1);
      check("single.coreid", 64'(out_coreid), 64'h2A);
      tick();
      check("single.gone", 64'(out_valid), 64'd0);
      check("single.hold", out_data, 64'hDEAD_BEEF);

      // out_coreid is registered: a change shows up one edge later.
      io_coreid = 8'h5C;
      check("coreid.old", 64'(out_coreid), 64'h2A);
      tick();
      check("coreid.new", 64'(out_coreid), 64'h5C);

      // Two-port stream with out_ready high: count climbs by one per cycle until in_ready falls.
      for (int j = 0; j < 12; j++) begin
         if (j <= 6) drive(2'b11, stream_ev(2 * j), stream_ev(2 * j + 1));
         else        idle();
         tick();
         check_head($sformatf("stream%0d", j), stream_ev(j));
         if (j == 5) check("stream.in_ready_low", 64'(in_ready), 64'd0);
         if (j == 6) begin
            check("stream.in_ready_back", 64'(in_ready), 64'd1);
            check("stream.ovf",           64'(overflow_cnt), 64'd2);
            check("stream.sticky",        64'(overflow_sticky), 64'd1);
         end
      end
      idle();
      tick();
      check("stream.empty", 64'(out_valid), 64'd0);
      check("stream.ovf_final", 64'(overflow_cnt), 64'd2);

      // Backpressure: offset pointers by 3 so the later drain wraps the buffer.
      do_reset();
      check("bp.ovf_cleared",    64'(overflow_cnt), 64'd0);
      check("bp.sticky_cleared", 64'(overflow_sticky), 64'd0);
      for (int j = 0; j < 3; j++) begin
         drive(2'b01, mk(31, 64'h55 + j), mk(0, 0));
         tick();
         check_head($sformatf("pre%0d", j), mk(31, 64'h55 + j));
      end
      idle();
      tick();
      check("pre.empty", 64'(out_valid), 64'd0);

      out_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         drive(2'b11, burst_ev(2 * b), burst_ev(2 * b + 1));
         tick();
      end
      check("bp.full_in_ready", 64'(in_ready), 64'd0);
      check("bp.full_ovf",      64'(overflow_cnt), 64'd0);
      check_head("bp.head", burst_ev(0));
      drive(2'b11, mk(9, 64'hF0), mk(9, 64'hF1));
      tick();
      idle();
      check("bp.drop_ovf",    64'(overflow_cnt), 64'd2);
      check("bp.drop_sticky", 64'(overflow_sticky), 64'd1);
      check_head("bp.head_kept", burst_ev(0));
      out_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         tick();
         check_head($sformatf("drain%0d", i), burst_ev(i));
      end
      tick();
      check("drain.empty",  64'(out_valid), 64'd0);
      check("drain.hold",   out_data, 64'h1007);
      check("drain.ovf",    64'(overflow_cnt), 64'd2);
      check("drain.sticky", 64'(overflow_sticky), 64'd1);

      // x0 writeback on port 0 alongside x7 on port 1.
      drive(2'b11, mk(0, 64'hA0), mk(7, 64'hB7));
      tick();
      idle();
`ifdef DIFFTEST_WB_FILTER_X0_EN
      check_head("x0.only_x7", mk(7, 64'hB7));
`else
      check_head("x0.first", mk(0, 64'hA0));
      tick();
      check_head("x0.second", mk(7, 64'hB7));
`endif
      tick();
      check("x0.empty", 64'(out_valid), 64'd0);
      check("x0.ovf",   64'(overflow_cnt), 64'd2);

      // Reset mid-drain with 5 entries queued.
      out_ready = 1'b0;
      drive(2'b11, mk(4, 64'h40), mk(5, 64'h50));
      tick();
      drive(2'b11, mk(6, 64'h60), mk(8, 64'h80));
      tick();
      drive(2'b01, mk(3, 64'h33), mk(0, 0));
      tick();
      idle();
      check_head("mid.head", mk(4, 64'h40));
      #2 reset = 1'b0;
      #1;
      check("mid.valid_async",  64'(out_valid), 64'd0);
      check("mid.in_ready",     64'(in_ready), 64'd0);
      check("mid.ovf",          64'(overflow_cnt), 64'd0);
      check("mid.sticky",       64'(overflow_sticky), 64'd0);
      tick();
      reset     = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("post.valid",    64'(out_valid), 64'd0);
         check("post.in_ready", 64'(in_ready), 64'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
